// File: rtl/skill_sweep_sequencer.sv
// Walks a registered year-indexed lookup table from START_YEAR to END_YEAR and offers
// each captured word as a {year, data} record on a valid/ready stream, with sweep statistics.
module skill_sweep_sequencer #(
  parameter int START_YEAR = 2014,
  parameter int END_YEAR   = 2024,
  parameter int LUT_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] year_addr_o,
  input  logic [31:0] lut_data_i,
  output logic        rec_valid_o,
  input  logic        rec_ready_i,
  output logic [31:0] rec_year_o,
  output logic [31:0] rec_data_o,
  output logic [2:0]  max_coffee_o,
  output logic [7:0]  nonzero_cnt_o
);

  localparam int CW    = (LUT_LAT < 1) ? 1 : $clog2(LUT_LAT + 1);
  localparam bit EMPTY = (START_YEAR > END_YEAR);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PRESENT, S_DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [31:0]   year_addr_reg, year_addr_next;
  logic          rec_valid_reg, rec_valid_next;
  logic [31:0]   rec_year_reg, rec_year_next;
  logic [31:0]   rec_data_reg, rec_data_next;
  logic [2:0]    max_coffee_reg, max_coffee_next;
  logic [7:0]    nonzero_cnt_reg, nonzero_cnt_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= S_IDLE;
      cnt_reg         <= '0;
      year_addr_reg   <= '0;
      rec_valid_reg   <= 1'b0;
      rec_year_reg    <= '0;
      rec_data_reg    <= '0;
      max_coffee_reg  <= '0;
      nonzero_cnt_reg <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      year_addr_reg   <= year_addr_next;
      rec_valid_reg   <= rec_valid_next;
      rec_year_reg    <= rec_year_next;
      rec_data_reg    <= rec_data_next;
      max_coffee_reg  <= max_coffee_next;
      nonzero_cnt_reg <= nonzero_cnt_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    year_addr_next   = year_addr_reg;
    rec_valid_next   = rec_valid_reg;
    rec_year_next    = rec_year_reg;
    rec_data_next    = rec_data_reg;
    max_coffee_next  = max_coffee_reg;
    nonzero_cnt_next = nonzero_cnt_reg;

    case (state_reg)
      S_IDLE: begin
        if (start_i) begin
          max_coffee_next  = '0;
          nonzero_cnt_next = '0;
          if (EMPTY) begin
            state_next = S_DONE;
          end else begin
            year_addr_next = 32'(START_YEAR);
            cnt_next       = CW'(LUT_LAT);
            state_next     = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (abort_i) begin
          state_next = S_IDLE;
        end else if (cnt_reg == '0) begin
          rec_data_next  = lut_data_i;
          rec_year_next  = year_addr_reg;
          rec_valid_next = 1'b1;
          state_next     = S_PRESENT;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      S_PRESENT: begin
        // Abort wins over a coincident handshake: the record is dropped uncounted.
        if (abort_i) begin
          rec_valid_next = 1'b0;
          state_next     = S_IDLE;
        end else if (rec_ready_i) begin
          rec_valid_next = 1'b0;
          if (rec_data_reg[8:6] > max_coffee_reg)
            max_coffee_next = rec_data_reg[8:6];
          if (rec_data_reg != '0 && nonzero_cnt_reg != 8'hFF)
            nonzero_cnt_next = nonzero_cnt_reg + 8'd1;
          if (rec_year_reg == 32'(END_YEAR)) begin
            state_next = S_DONE;
          end else begin
            year_addr_next = rec_year_reg + 32'd1;
            cnt_next       = CW'(LUT_LAT);
            state_next     = S_WAIT;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy_o        = (state_reg == S_WAIT) || (state_reg == S_PRESENT);
  assign done_o        = (state_reg == S_DONE);
  assign year_addr_o   = year_addr_reg;
  assign rec_valid_o   = rec_valid_reg;
  assign rec_year_o    = rec_year_reg;
  assign rec_data_o    = rec_data_reg;
  assign max_coffee_o  = max_coffee_reg;
  assign nonzero_cnt_o = nonzero_cnt_reg;

endmodule

// File: tb/tb_skill_sweep_sequencer.sv
// Bench for skill_sweep_sequencer: default, empty-range and single-year instances,
// each fed by a bench-owned registered table and checked against a record-queue model.
module tb_skill_sweep_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 0, abort_a = 0, ready_a = 0;
  logic        busy_a, done_a, valid_a;
  logic [31:0] year_addr_a, lut_a, year_a, data_a;
  logic [2:0]  maxc_a;
  logic [7:0]  nz_a;

  logic        start_b = 0, start_c = 0, ready_c = 0, abort_bc = 0, ready_b = 1;
  logic        busy_b, done_b, valid_b, busy_c, done_c, valid_c;
  logic [31:0] year_addr_b, lut_b, year_b, data_b, year_addr_c, lut_c, year_c, data_c;
  logic [2:0]  maxc_b, maxc_c;
  logic [7:0]  nz_b, nz_c;

  logic [31:0] tbl [2014:2024];
  int tests_run = 0;
  int tests_failed = 0;

  skill_sweep_sequencer dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .abort_i(abort_a), .busy_o(busy_a), .done_o(done_a),
    .year_addr_o(year_addr_a), .lut_data_i(lut_a), .rec_valid_o(valid_a), .rec_ready_i(ready_a),
    .rec_year_o(year_a), .rec_data_o(data_a), .max_coffee_o(maxc_a), .nonzero_cnt_o(nz_a));

  skill_sweep_sequencer #(.START_YEAR(2030), .END_YEAR(2020), .LUT_LAT(1)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .abort_i(abort_bc), .busy_o(busy_b), .done_o(done_b),
    .year_addr_o(year_addr_b), .lut_data_i(lut_b), .rec_valid_o(valid_b), .rec_ready_i(ready_b),
    .rec_year_o(year_b), .rec_data_o(data_b), .max_coffee_o(maxc_b), .nonzero_cnt_o(nz_b));

  skill_sweep_sequencer #(.START_YEAR(2025), .END_YEAR(2025), .LUT_LAT(1)) dut_c (
    .clk(clk), .rst(rst), .start_i(start_c), .abort_i(abort_bc), .busy_o(busy_c), .done_o(done_c),
    .year_addr_o(year_addr_c), .lut_data_i(lut_c), .rec_valid_o(valid_c), .rec_ready_i(ready_c),
    .rec_year_o(year_c), .rec_data_o(data_c), .max_coffee_o(maxc_c), .nonzero_cnt_o(nz_c));

  function automatic logic [31:0] lut_word(input logic [31:0] y);
    if (y >= 32'd2014 && y <= 32'd2024) return tbl[y];
    return 32'd0;
  endfunction

  // Skills table stand-in: one-cycle registered read.
  always @(posedge clk) begin
    lut_a <= lut_word(year_addr_a);
    lut_b <= lut_word(year_addr_b);
    lut_c <= lut_word(year_addr_c);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic init_table(input bit rand_fill);
    for (int y = 2014; y <= 2024; y++)
      tbl[y] = rand_fill ? ((($urandom % 4) == 0) ? 32'd0 : $urandom) : ($urandom | 32'd1);
    if (!rand_fill) begin
      tbl[2014] = 32'h0E063FDF;
      tbl[2019] = 32'h7FFFFF1D;
      tbl[2024] = 32'h7FFFFF61;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) tick();
    tests_run++;
    if ({busy_a, done_a, valid_a} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_flags got %b exp 000", {busy_a, done_a, valid_a});
    end
    tests_run++;
    if (year_addr_a !== 32'd0) begin
      tests_failed++; $display("FAIL reset_year_addr got %0d exp 0", year_addr_a);
    end
    tests_run++;
    if ({year_a, data_a} !== 64'd0) begin
      tests_failed++; $display("FAIL reset_record got %0h/%0h exp 0/0", year_a, data_a);
    end
    tests_run++;
    if ({maxc_a, nz_a} !== 11'd0) begin
      tests_failed++; $display("FAIL reset_stats got %0d/%0d exp 0/0", maxc_a, nz_a);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_full_sweep;
    logic [31:0] gy[$], gd[$];
    int n, first_valid, done_n, exp_nz;
    logic [2:0] exp_max;
    init_table(0);
    exp_nz = 0; exp_max = 0;
    for (int y = 2014; y <= 2024; y++) begin
      if (tbl[y] != 0) exp_nz++;
      if (tbl[y][8:6] > exp_max) exp_max = tbl[y][8:6];
    end
    ready_a = 1; start_a = 1;
    tick();
    start_a = 0; n = 1; first_valid = 0; done_n = 0;
    while (n < 100 && done_n == 0) begin
      if (valid_a) begin
        if (first_valid == 0) first_valid = n;
        gy.push_back(year_a); gd.push_back(data_a);
      end
      tick(); n++;
      if (done_a) done_n = n;
    end
    tests_run++;
    if (done_n != 34) begin
      tests_failed++; $display("FAIL full_done_cycle got %0d exp 34", done_n);
    end
    tests_run++;
    if (first_valid != 3) begin
      tests_failed++; $display("FAIL full_first_valid got %0d exp 3", first_valid);
    end
    tests_run++;
    if (gy.size() != 11) begin
      tests_failed++; $display("FAIL full_record_count got %0d exp 11", gy.size());
    end
    for (int i = 0; i < gy.size() && i < 11; i++) begin
      tests_run++;
      if (gy[i] !== 32'(2014 + i) || gd[i] !== lut_word(32'(2014 + i))) begin
        tests_failed++;
        $display("FAIL full_record_%0d got %0d/%0h exp %0d/%0h", i, gy[i], gd[i], 2014 + i, lut_word(32'(2014 + i)));
      end
    end
    if (gd.size() == 11) begin
      tests_run++;
      if (gd[0] !== 32'h0E063FDF || gd[5] !== 32'h7FFFFF1D || gd[10] !== 32'h7FFFFF61) begin
        tests_failed++; $display("FAIL full_known_words got %0h %0h %0h exp 0e063fdf 7fffff1d 7fffff61", gd[0], gd[5], gd[10]);
      end
    end
    tests_run++;
    if (nz_a !== 8'(exp_nz) || nz_a !== 8'd11) begin
      tests_failed++; $display("FAIL full_nonzero got %0d exp %0d", nz_a, exp_nz);
    end
    tests_run++;
    if (maxc_a !== exp_max || maxc_a !== 3'd7) begin
      tests_failed++; $display("FAIL full_max_coffee got %0d exp %0d", maxc_a, exp_max);
    end
    // start raised during the done cycle must not launch a sweep
    start_a = 1;
    tick();
    start_a = 0;
    tests_run++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      tests_failed++; $display("FAIL done_pulse_width got done=%b busy=%b exp 0/0", done_a, busy_a);
    end
    tick();
    tests_run++;
    if (busy_a !== 1'b0 || nz_a !== 8'd11) begin
      tests_failed++; $display("FAIL start_in_done got busy=%b nz=%0d exp 0/11", busy_a, nz_a);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] gy[$];
    int n;
    bit held;
    init_table(0);
    ready_a = 1; start_a = 1;
    tick();
    start_a = 0; n = 0; held = 0;
    while (n < 150 && !done_a) begin
      if (valid_a && year_a == 32'd2015 && !held) begin
        held = 1; ready_a = 0; gy.push_back(year_a);
        repeat (5) begin
          tick(); n++;
          tests_run++;
          if (valid_a !== 1'b1 || year_a !== 32'd2015 || data_a !== lut_word(32'd2015) || year_addr_a !== 32'd2015) begin
            tests_failed++;
            $display("FAIL hold_stable got v=%b y=%0d d=%0h a=%0d exp 1/2015/%0h/2015", valid_a, year_a, data_a, year_addr_a, lut_word(32'd2015));
          end
        end
        ready_a = 1;
      end else if (valid_a) begin
        gy.push_back(year_a);
      end
      tick(); n++;
    end
    tests_run++;
    if (done_a !== 1'b1 || gy.size() != 11) begin
      tests_failed++; $display("FAIL hold_sweep got done=%b count=%0d exp 1/11", done_a, gy.size());
    end
    for (int i = 0; i < gy.size() && i < 11; i++) begin
      tests_run++;
      if (gy[i] !== 32'(2014 + i)) begin
        tests_failed++; $display("FAIL hold_order_%0d got %0d exp %0d", i, gy[i], 2014 + i);
      end
    end
    tick();
  endtask

  task automatic test_abort;
    int n, exp_nz;
    logic [2:0] exp_max;
    bit hit;
    logic [7:0] nz_hold;
    init_table(0);
    exp_nz = 0; exp_max = 0;
    for (int y = 2014; y < 2017; y++) begin
      if (tbl[y] != 0) exp_nz++;
      if (tbl[y][8:6] > exp_max) exp_max = tbl[y][8:6];
    end
    ready_a = 1; start_a = 1;
    tick();
    start_a = 0; n = 0; hit = 0;
    while (n < 60 && !hit) begin
      if (valid_a && year_a == 32'd2017) begin
        hit = 1; abort_a = 1;
      end
      tick(); n++;
      abort_a = 0;
    end
    tests_run++;
    if (!hit || busy_a !== 1'b0 || valid_a !== 1'b0 || done_a !== 1'b0) begin
      tests_failed++; $display("FAIL abort_state got hit=%b busy=%b v=%b done=%b exp 1/0/0/0", hit, busy_a, valid_a, done_a);
    end
    tests_run++;
    if (nz_a !== 8'(exp_nz) || nz_a !== 8'd3 || maxc_a !== exp_max) begin
      tests_failed++; $display("FAIL abort_stats got nz=%0d max=%0d exp %0d/%0d", nz_a, maxc_a, exp_nz, exp_max);
    end
    tests_run++;
    if (year_addr_a !== 32'd2017) begin
      tests_failed++; $display("FAIL abort_year_addr got %0d exp 2017", year_addr_a);
    end
    nz_hold = nz_a;
    abort_a = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (done_a !== 1'b0 || busy_a !== 1'b0 || nz_a !== nz_hold) begin
        tests_failed++; $display("FAIL abort_idle_%0d got done=%b busy=%b nz=%0d exp 0/0/%0d", k, done_a, busy_a, nz_a, nz_hold);
      end
    end
    abort_a = 0;
  endtask

  task automatic test_random;
    logic [31:0] exp_q[$];
    logic [31:0] y;
    int n, mnz;
    logic [2:0] mmax;
    bit aborted;
    for (int s = 0; s < 6; s++) begin
      init_table(1);
      exp_q.delete();
      for (int k = 2014; k <= 2024; k++) exp_q.push_back(32'(k));
      mnz = 0; mmax = 0; aborted = 0; n = 0;
      start_a = 1;
      tick();
      start_a = 0;
      while (n < 400 && !done_a && !aborted) begin
        ready_a = ($urandom % 3) != 0;
        abort_a = busy_a && (s % 2 == 1) && (($urandom % 40) == 0);
        start_a = busy_a && (($urandom % 6) == 0);
        if (abort_a) begin
          aborted = 1;
        end else if (valid_a && ready_a) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++; $display("FAIL rand_extra_record got %0d exp none", year_a);
          end else begin
            y = exp_q.pop_front();
            if (year_a !== y || data_a !== lut_word(y)) begin
              tests_failed++; $display("FAIL rand_record got %0d/%0h exp %0d/%0h", year_a, data_a, y, lut_word(y));
            end
            if (lut_word(y) != 0 && mnz < 255) mnz++;
            if (lut_word(y)[8:6] > mmax) mmax = lut_word(y)[8:6];
          end
        end
        tick(); n++;
      end
      start_a = 0; abort_a = 0;
      tests_run++;
      if (aborted) begin
        if (busy_a !== 1'b0 || valid_a !== 1'b0 || done_a !== 1'b0) begin
          tests_failed++; $display("FAIL rand_abort got busy=%b v=%b done=%b exp 0/0/0", busy_a, valid_a, done_a);
        end
      end else if (done_a !== 1'b1 || exp_q.size() != 0) begin
        tests_failed++; $display("FAIL rand_sweep_end got done=%b left=%0d exp 1/0", done_a, exp_q.size());
      end
      tests_run++;
      if (nz_a !== 8'(mnz) || maxc_a !== mmax) begin
        tests_failed++; $display("FAIL rand_stats got nz=%0d max=%0d exp %0d/%0d", nz_a, maxc_a, mnz, mmax);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    int n;
    init_table(0);
    ready_a = 1; start_a = 1;
    tick();
    start_a = 0;
    repeat (10) tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if ({busy_a, done_a, valid_a, year_addr_a, year_a, data_a, maxc_a, nz_a} !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset got busy=%b v=%b addr=%0d y=%0d d=%0h max=%0d nz=%0d exp all 0", busy_a, valid_a, year_addr_a, year_a, data_a, maxc_a, nz_a);
    end
    rst = 1'b1;
    tick();
    start_a = 1;
    tick();
    start_a = 0; n = 0;
    while (n < 20 && !valid_a) begin
      tick(); n++;
    end
    tests_run++;
    if (valid_a !== 1'b1 || year_a !== 32'd2014 || nz_a !== 8'd0) begin
      tests_failed++; $display("FAIL mid_restart got v=%b y=%0d nz=%0d exp 1/2014/0", valid_a, year_a, nz_a);
    end
    tick();
    tests_run++;
    if (nz_a !== 8'd1 || maxc_a !== tbl[2014][8:6]) begin
      tests_failed++; $display("FAIL mid_first_stats got nz=%0d max=%0d exp 1/%0d", nz_a, maxc_a, tbl[2014][8:6]);
    end
    abort_a = 1;
    tick();
    abort_a = 0;
    tick();
  endtask

  task automatic test_empty;
    int done_n;
    bit saw_valid;
    start_b = 1;
    tick();
    start_b = 0; done_n = 0; saw_valid = 0;
    if (done_b) done_n = 1;
    for (int n = 2; n < 10; n++) begin
      if (valid_b || busy_b) saw_valid = 1;
      tick();
      if (done_b && done_n == 0) done_n = n;
    end
    tests_run++;
    if (done_n != 1) begin
      tests_failed++; $display("FAIL empty_done_cycle got %0d exp 1", done_n);
    end
    tests_run++;
    if (saw_valid || done_b !== 1'b0 || nz_b !== 8'd0 || maxc_b !== 3'd0) begin
      tests_failed++; $display("FAIL empty_outputs got v=%b done=%b nz=%0d max=%0d exp 0/0/0/0", saw_valid, done_b, nz_b, maxc_b);
    end
  endtask

  task automatic test_single;
    logic [31:0] gy[$], gd[$];
    int n;
    ready_c = 1; start_c = 1;
    tick();
    start_c = 0; n = 0;
    while (n < 30 && !done_c) begin
      if (valid_c) begin
        gy.push_back(year_c); gd.push_back(data_c);
      end
      tick(); n++;
    end
    tests_run++;
    if (done_c !== 1'b1 || gy.size() != 1) begin
      tests_failed++; $display("FAIL single_count got done=%b count=%0d exp 1/1", done_c, gy.size());
    end else begin
      tests_run++;
      if (gy[0] !== 32'd2025 || gd[0] !== 32'd0) begin
        tests_failed++; $display("FAIL single_record got %0d/%0h exp 2025/0", gy[0], gd[0]);
      end
    end
    tests_run++;
    if (nz_c !== 8'd0 || maxc_c !== 3'd0) begin
      tests_failed++; $display("FAIL single_stats got nz=%0d max=%0d exp 0/0", nz_c, maxc_c);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_backpressure();
    test_abort();
    test_random();
    test_reset_mid();
    test_empty();
    test_single();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
